// File: rtl/friscv_sv_pkg.sv
// Shared types for the core memory subsystem: architecture width and arbiter owner tags.
// No logic; pure declarations.
// No flow control; consumers decide how these types are registered.
package friscv_sv_pkg;

  localparam int ARCH = 32;

  // Which requester owns the read response returning next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

  // Winner of the most recent contention (round-robin build only).
  typedef enum logic {
    WIN_IF = 1'b0,
    WIN_D  = 1'b1
  } arb_win_e;

endpackage

// File: rtl/mem_arb_policy.sv
// Contention resolver for the fetch/data SRAM arbiter; grants are combinational.
// Latency: 0 cycles from request to grant; state updates on the clock edge.
// Optional macro MEM_ARB_RR_EN selects round-robin; default is data priority with a fetch starvation guard.
module mem_arb_policy
  import friscv_sv_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic if_gnt_o,
  output logic d_gnt_o
);

  logic contend;
  assign contend = if_req_i & d_req_i;

`ifdef MEM_ARB_RR_EN

  arb_win_e last_q, last_d;

  // Lone requester wins; on contention the port that lost last time wins.
  always_comb begin
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    last_d   = last_q;
    if (!rst) begin
      if (contend) begin
        if (last_q == WIN_IF) begin
          d_gnt_o = 1'b1;
          last_d  = WIN_D;
        end else begin
          if_gnt_o = 1'b1;
          last_d   = WIN_IF;
        end
      end else begin
        if_gnt_o = if_req_i;
        d_gnt_o  = d_req_i;
      end
    end
  end

  // Last-winner register; resets to IF so the first contention goes to data.
  always_ff @(posedge clk) begin
    if (rst) last_q <= WIN_IF;
    else     last_q <= last_d;
  end

`else

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_q, wait_d;
  logic          starved;
  assign starved = (wait_q == CW'(MAX_WAIT));

  // Data wins contention unless fetch has lost MAX_WAIT times in a row.
  always_comb begin
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    wait_d   = wait_q;
    if (!rst) begin
      if (contend) begin
        if (starved) if_gnt_o = 1'b1;
        else         d_gnt_o  = 1'b1;
      end else begin
        if_gnt_o = if_req_i;
        d_gnt_o  = d_req_i;
      end
      if (if_gnt_o)                wait_d = '0;
      else if (contend && !starved) wait_d = wait_q + CW'(1);
    end
  end

  // Starvation counter: clears on fetch grant, saturates at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch + data) arbiter onto one synchronous SRAM port; MEM_ARB_RR_EN selects round-robin contention.
// Latency: grant and mem_* combinational in cycle N; read data returns with rvalid at N+1.
// Backpressure: a request is held by the requester until its gnt is seen; one access per cycle sustained.
module mem_arbiter
  import friscv_sv_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = ARCH,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_gnt_out,
  output logic              if_rvalid_out,
  output logic [DATA_W-1:0] if_rdata_out,
  input  logic              d_req_in,
  input  logic              d_we_in,
  input  logic [ADDR_W-1:0] d_addr_in,
  input  logic [DATA_W-1:0] d_wdata_in,
  output logic              d_gnt_out,
  output logic              d_rvalid_out,
  output logic [DATA_W-1:0] d_rdata_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_we_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  input  logic [DATA_W-1:0] mem_rdata_in
);

  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  mem_arb_policy #(
    .MAX_WAIT (MAX_WAIT)
  ) u_policy (
    .clk      (clk),
    .rst      (rst),
    .if_req_i (if_req_in),
    .d_req_i  (d_req_in),
    .if_gnt_o (if_gnt_out),
    .d_gnt_o  (d_gnt_out)
  );

  // Shared SRAM port mux and next response owner; address parks on its last value when idle.
  always_comb begin
    mem_addr_d    = mem_addr_q;
    mem_we_out    = 1'b0;
    mem_wdata_out = '0;
    owner_d       = OWN_NONE;
    if (if_gnt_out) begin
      mem_addr_d = if_addr_in;
      owner_d    = OWN_IF;
    end else if (d_gnt_out) begin
      mem_addr_d    = d_addr_in;
      mem_we_out    = d_we_in;
      mem_wdata_out = d_wdata_in;
      owner_d       = d_we_in ? OWN_NONE : OWN_D;
    end
    mem_addr_out = rst ? '0 : mem_addr_d;
  end

  // Response owner and parked address; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      mem_addr_q <= '0;
    end else begin
      owner_q    <= owner_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Response routing: only the registered owner decides who sees rvalid; data is zero otherwise.
  always_comb begin
    if_rvalid_out = !rst && (owner_q == OWN_IF);
    d_rvalid_out  = !rst && (owner_q == OWN_D);
    if_rdata_out  = if_rvalid_out ? mem_rdata_in : '0;
    d_rdata_out   = d_rvalid_out  ? mem_rdata_in : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus contention/reset sequences.
// A behavioural 1-cycle SRAM sits on the shared port.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk, rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_in     (if_req),
    .if_addr_in    (if_addr),
    .if_gnt_out    (if_gnt),
    .if_rvalid_out (if_rvalid),
    .if_rdata_out  (if_rdata),
    .d_req_in      (d_req),
    .d_we_in       (d_we),
    .d_addr_in     (d_addr),
    .d_wdata_in    (d_wdata),
    .d_gnt_out     (d_gnt),
    .d_rvalid_out  (d_rvalid),
    .d_rdata_out   (d_rdata),
    .mem_addr_out  (mem_addr),
    .mem_we_out    (mem_we),
    .mem_wdata_out (mem_wdata),
    .mem_rdata_in  (mem_rdata)
  );

  // Behavioural SRAM: word-addressed by byte address, one-cycle read latency.
  logic [DW-1:0] sram [0:1023];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr[AW-1:2]] <= mem_wdata;
    mem_rdata <= sram[mem_addr[AW-1:2]];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          e_if_gnt;
    logic          e_d_gnt;
    logic [AW-1:0] e_mem_addr;
    logic          e_mem_we;
    logic          e_if_rvalid;
    logic [DW-1:0] e_if_rdata;
    logic          e_d_rvalid;
    logic [DW-1:0] e_d_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic ir, logic [AW-1:0] ia, logic dr, logic dwe,
                              logic [AW-1:0] da, logic [DW-1:0] dwd, logic eig, logic edg,
                              logic [AW-1:0] ema, logic emw, logic eiv, logic [DW-1:0] eid,
                              logic edv, logic [DW-1:0] edd);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dwe;
    v.d_addr = da; v.d_wdata = dwd; v.e_if_gnt = eig; v.e_d_gnt = edg;
    v.e_mem_addr = ema; v.e_mem_we = emw; v.e_if_rvalid = eiv; v.e_if_rdata = eid;
    v.e_d_rvalid = edv; v.e_d_rdata = edd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ir, input logic [AW-1:0] ia, input logic dr,
                       input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    next_cycle();
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    sram[12'h010 >> 2] = 32'h00500093;
    sram[12'h030 >> 2] = 32'h11112222;
    mem_rdata = '0;

    //          rst ir  ia      dr  we  da      wdata         ig  dg  maddr   mwe irv  irdata        drv  drdata
    vecs[0]  = mk(1, 1, 12'h010, 1, 1, 12'h020, 32'h12345678, 0, 0, 12'h000, 0, 0, 32'h0,         0, 32'h0);
    vecs[1]  = mk(1, 0, 12'h000, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 0, 0, 32'h0,         0, 32'h0);
    vecs[2]  = mk(0, 1, 12'h010, 0, 0, 12'h000, 32'h0,        1, 0, 12'h010, 0, 0, 32'h0,         0, 32'h0);
    vecs[3]  = mk(0, 0, 12'h000, 0, 0, 12'h000, 32'h0,        0, 0, 12'h010, 0, 1, 32'h00500093,  0, 32'h0);
    vecs[4]  = mk(0, 0, 12'h000, 1, 1, 12'h020, 32'hDEADBEEF, 0, 1, 12'h020, 1, 0, 32'h0,         0, 32'h0);
    vecs[5]  = mk(0, 0, 12'h000, 1, 0, 12'h020, 32'h0,        0, 1, 12'h020, 0, 0, 32'h0,         0, 32'h0);
    vecs[6]  = mk(0, 0, 12'h000, 0, 0, 12'h000, 32'h0,        0, 0, 12'h020, 0, 0, 32'h0,         1, 32'hDEADBEEF);
    vecs[7]  = mk(0, 0, 12'h000, 1, 0, 12'h030, 32'h0,        0, 1, 12'h030, 0, 0, 32'h0,         0, 32'h0);
    vecs[8]  = mk(0, 1, 12'h020, 0, 0, 12'h000, 32'h0,        1, 0, 12'h020, 0, 0, 32'h0,         1, 32'h11112222);
    vecs[9]  = mk(0, 0, 12'h000, 1, 0, 12'h010, 32'h0,        0, 1, 12'h010, 0, 1, 32'hDEADBEEF,  0, 32'h0);
    vecs[10] = mk(0, 0, 12'h000, 0, 0, 12'h000, 32'h0,        0, 0, 12'h010, 0, 0, 32'h0,         1, 32'h00500093);
    vecs[11] = mk(0, 0, 12'h000, 0, 0, 12'h000, 32'h0,        0, 0, 12'h010, 0, 0, 32'h0,         0, 32'h0);
    vecs[12] = mk(0, 1, 12'h010, 1, 0, 12'h030, 32'h0,        0, 1, 12'h030, 0, 0, 32'h0,         0, 32'h0);
    vecs[13] = mk(0, 1, 12'h010, 0, 0, 12'h000, 32'h0,        1, 0, 12'h010, 0, 0, 32'h0,         1, 32'h11112222);
    vecs[14] = mk(0, 0, 12'h000, 0, 0, 12'h000, 32'h0,        0, 0, 12'h010, 0, 1, 32'h00500093,  0, 32'h0);

    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    next_cycle();

    // Table-driven cycle-by-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req, vecs[i].d_we,
            vecs[i].d_addr, vecs[i].d_wdata);
      @(negedge clk);
      chk($sformatf("v%0d if_gnt", i),    32'(if_gnt),    32'(vecs[i].e_if_gnt));
      chk($sformatf("v%0d d_gnt", i),     32'(d_gnt),     32'(vecs[i].e_d_gnt));
      chk($sformatf("v%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_mem_addr));
      chk($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(vecs[i].e_mem_we));
      chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].e_if_rvalid));
      chk($sformatf("v%0d if_rdata", i),  if_rdata,       vecs[i].e_if_rdata);
      chk($sformatf("v%0d d_rvalid", i),  32'(d_rvalid),  32'(vecs[i].e_d_rvalid));
      chk($sformatf("v%0d d_rdata", i),   d_rdata,        vecs[i].e_d_rdata);
      next_cycle();
    end

    // Sustained contention: both ports read every cycle.
    do_reset();
    begin
      logic prev_if;
      logic exp_if;
      int   ncyc;
      prev_if = 1'b0;
`ifdef MEM_ARB_RR_EN
      ncyc = 4;
`else
      ncyc = 10;
`endif
      for (int i = 0; i < ncyc; i++) begin
        drive(1'b0, 1'b1, 12'h010, 1'b1, 1'b0, 12'h030, '0);
`ifdef MEM_ARB_RR_EN
        exp_if = (i % 2) == 1;
`else
        exp_if = (i == 4) || (i == 9);
`endif
        @(negedge clk);
        chk($sformatf("cont%0d if_gnt", i), 32'(if_gnt), 32'(exp_if));
        chk($sformatf("cont%0d d_gnt", i),  32'(d_gnt),  32'(!exp_if));
        if (i > 0) begin
          chk($sformatf("cont%0d if_rvalid", i), 32'(if_rvalid), 32'(prev_if));
          chk($sformatf("cont%0d d_rvalid", i),  32'(d_rvalid),  32'(!prev_if));
          chk($sformatf("cont%0d rdata", i), prev_if ? if_rdata : d_rdata,
              prev_if ? 32'h00500093 : 32'h11112222);
        end
`ifndef MEM_ARB_RR_EN
        if (i == 4) chk("cont4 counter at limit", 32'(dut.u_policy.wait_q), 32'd4);
`endif
        prev_if = exp_if;
        next_cycle();
`ifndef MEM_ARB_RR_EN
        if (i == 4) chk("cont4 counter cleared", 32'(dut.u_policy.wait_q), 32'd0);
`endif
      end
    end

`ifndef MEM_ARB_RR_EN
    // Counter holds while fetch is idle and no contention occurs.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic both;
      logic exp_if;
      both   = !(i >= 2 && i <= 4);
      exp_if = (i == 7);
      drive(1'b0, both, 12'h010, 1'b1, 1'b0, 12'h030, '0);
      @(negedge clk);
      if (i == 4) chk("hold counter", 32'(dut.u_policy.wait_q), 32'd2);
      chk($sformatf("hold%0d if_gnt", i), 32'(if_gnt), 32'(exp_if));
      chk($sformatf("hold%0d d_gnt", i),  32'(d_gnt),  32'(!exp_if));
      next_cycle();
    end
`endif

    // Reset mid-operation drops an in-flight fetch read.
    do_reset();
    drive(1'b0, 1'b1, 12'h010, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rstmid N if_gnt", 32'(if_gnt), 32'd1);
    next_cycle();
    drive(1'b1, 1'b1, 12'h010, 1'b1, 1'b0, 12'h020, '0);
    @(negedge clk);
    chk("rstmid N+1 if_gnt", 32'(if_gnt), 32'd0);
    chk("rstmid N+1 d_gnt", 32'(d_gnt), 32'd0);
    chk("rstmid N+1 if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rstmid N+1 if_rdata", if_rdata, 32'h0);
    chk("rstmid N+1 mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 12'h020, '0);
    @(negedge clk);
    chk("rstmid N+2 if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rstmid N+2 d_gnt", 32'(d_gnt), 32'd1);
`ifndef MEM_ARB_RR_EN
    chk("rstmid N+2 counter", 32'(dut.u_policy.wait_q), 32'd0);
`endif
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rstmid N+3 d_rvalid", 32'(d_rvalid), 32'd1);
    chk("rstmid N+3 d_rdata", d_rdata, 32'hDEADBEEF);
    chk("rstmid N+3 if_rvalid", 32'(if_rvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
